// File: rtl/quad_encoder_gen.sv
// Quadrature stimulus generator: turns "rotate N detents" commands into Gray-coded A/B waveforms.
// Latency: first A/B change PHASE_TICKS cycles after acceptance; done pulses (4N+1)*PHASE_TICKS after it.
// Backpressure: cmd_ready low for the whole RUN; cmd_valid while busy is dropped, nothing is queued.
// Optional: define QUAD_ENCODER_GEN_POS_EN to add a 0..100 saturating detent position output.
module quad_encoder_gen #(
    parameter int PHASE_TICKS = 125000,
    parameter int PHASE_W     = 17,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_count,
    output logic             enc_A,
    output logic             enc_B,
    output logic             busy,
    output logic             done
`ifdef QUAD_ENCODER_GEN_POS_EN
    ,
    output logic [7:0]       position
`endif
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [PHASE_W-1:0] TIMER_MAX = PHASE_W'(PHASE_TICKS - 1);

    state_t             state_q, state_d;
    logic [PHASE_W-1:0] timer_q, timer_d;
    // Remaining quarter-steps; two extra bits so 4*(2^CNT_W-1) fits.
    logic [CNT_W+1:0]   rem_q, rem_d;
    logic               dir_q, dir_d;
    logic               a_q, a_d;
    logic               b_q, b_d;
    logic               done_q, done_d;
`ifdef QUAD_ENCODER_GEN_POS_EN
    logic [7:0]         pos_q, pos_d;
`endif

    // Next-state: accept commands in IDLE, step the Gray sequence on each timer wrap in RUN.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        rem_d   = rem_q;
        dir_d   = dir_q;
        a_d     = a_q;
        b_d     = b_q;
        done_d  = 1'b0;
`ifdef QUAD_ENCODER_GEN_POS_EN
        pos_d   = pos_q;
`endif
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    dir_d = cmd_dir;
                    if (cmd_count == '0) begin
                        // Empty command: acknowledge immediately, outputs untouched.
                        done_d = 1'b1;
                    end else begin
                        state_d = RUN;
                        rem_d   = {cmd_count, 2'b00};
                        timer_d = '0;
                    end
                end
            end
            RUN: begin
                if (timer_q == TIMER_MAX) begin
                    timer_d = '0;
                    if (rem_q != '0) begin
                        rem_d = rem_q - 1'b1;
                        // Up: 00->10->11->01, down: 00->01->11->10; one bit flips per step.
                        if (dir_q) begin
                            a_d = ~b_q;
                            b_d = a_q;
                        end else begin
                            a_d = b_q;
                            b_d = ~a_q;
                        end
`ifdef QUAD_ENCODER_GEN_POS_EN
                        // A detent completes on the step back to rest.
                        if (!a_d && !b_d) begin
                            if (dir_q) begin
                                if (pos_q < 8'd100) pos_d = pos_q + 8'd1;
                            end else begin
                                if (pos_q != 8'd0) pos_d = pos_q - 8'd1;
                            end
                        end
`endif
                    end else begin
                        // Rest period after the last step has elapsed.
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous active-low reset; reset drops any in-flight command.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            timer_q <= '0;
            rem_q   <= '0;
            dir_q   <= 1'b0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            done_q  <= 1'b0;
`ifdef QUAD_ENCODER_GEN_POS_EN
            pos_q   <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            rem_q   <= rem_d;
            dir_q   <= dir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            done_q  <= done_d;
`ifdef QUAD_ENCODER_GEN_POS_EN
            pos_q   <= pos_d;
`endif
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q == RUN);
    assign enc_A     = a_q;
    assign enc_B     = b_q;
    assign done      = done_q;
`ifdef QUAD_ENCODER_GEN_POS_EN
    assign position  = pos_q;
`endif

endmodule

// File: tb/tb_quad_encoder_gen.sv
// Bench for quad_encoder_gen with PHASE_TICKS=4: directed commands plus random ones with
// random ignored cmd_valid noise while busy, checked every cycle against a timing model
// that derives A/B, busy, done and position from the cycles elapsed since acceptance.
module tb_quad_encoder_gen;

    localparam int P = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_dir;
    logic [7:0] cmd_count;
    logic       enc_A;
    logic       enc_B;
    logic       busy;
    logic       done;
`ifdef QUAD_ENCODER_GEN_POS_EN
    logic [7:0] position;
`endif

    int vectors     = 0;
    int miscompares = 0;
    int pos_m       = 0;

    // Expected (A,B) after a given number of quarter-steps, index = steps mod 4.
    logic [1:0] up_tab [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
    logic [1:0] dn_tab [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    quad_encoder_gen #(
        .PHASE_TICKS(P),
        .PHASE_W    (3),
        .CNT_W      (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_dir  (cmd_dir),
        .cmd_count(cmd_count),
        .enc_A    (enc_A),
        .enc_B    (enc_B),
        .busy     (busy),
        .done     (done)
`ifdef QUAD_ENCODER_GEN_POS_EN
        ,
        .position (position)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_A"}, 32'(enc_A), 0);
        chk({tag, "_B"}, 32'(enc_B), 0);
        chk({tag, "_ready"}, 32'(cmd_ready), 1);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
`ifdef QUAD_ENCODER_GEN_POS_EN
        chk({tag, "_pos"}, 32'(position), 32'(pos_m));
`endif
    endtask

    // Issue one command at the current negedge and check every cycle until it retires.
    // abort_at >= 0 pulls reset low that many cycles after acceptance.
    task automatic run_cmd(input bit dir, input int n, input bit noise, input int abort_at);
        int total, last, steps, det, pexp;
        bit aborted;
        logic [1:0] ab;
        aborted = 1'b0;
        pexp    = pos_m;
        chk("ready_before_cmd", 32'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_dir   = dir;
        cmd_count = 8'(n);
        total = (n == 0) ? 0 : (4 * n + 1) * P;
        last  = (n == 0) ? 1 : total + 1;
        @(posedge clk);
        for (int d = 0; d <= last; d++) begin
            @(negedge clk);
            steps = (n == 0) ? 0 : ((d / P < 4 * n) ? d / P : 4 * n);
            ab    = dir ? up_tab[steps % 4] : dn_tab[steps % 4];
            det   = steps / 4;
            pexp  = dir ? ((pos_m + det > 100) ? 100 : pos_m + det)
                        : ((pos_m - det < 0) ? 0 : pos_m - det);
            chk("enc_A", 32'(enc_A), 32'(ab[1]));
            chk("enc_B", 32'(enc_B), 32'(ab[0]));
            chk("busy", 32'(busy), 32'(n != 0 && d < total));
            chk("cmd_ready", 32'(cmd_ready), 32'(!(n != 0 && d < total)));
            chk("done", 32'(done), 32'((n == 0) ? (d == 0) : (d == total)));
`ifdef QUAD_ENCODER_GEN_POS_EN
            chk("position", 32'(position), 32'(pexp));
`endif
            if (d == abort_at) begin
                reset     = 1'b0;
                cmd_valid = 1'b0;
                @(negedge clk);
                pos_m = 0;
                chk_idle("abort_reset");
                reset = 1'b1;
                @(negedge clk);
                chk_idle("abort_after");
                aborted = 1'b1;
                break;
            end
            // Random commands while busy must be ignored.
            cmd_valid = noise && (n != 0) && (d < total) && ($urandom_range(0, 2) == 0);
            cmd_dir   = 1'($urandom);
            cmd_count = 8'($urandom);
        end
        cmd_valid = 1'b0;
        if (!aborted) pos_m = pexp;
    endtask

    initial begin
        reset     = 1'b0;
        cmd_valid = 1'b0;
        cmd_dir   = 1'b0;
        cmd_count = 8'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_idle("reset");
        reset = 1'b1;
        @(negedge clk);
        chk_idle("post_reset");

        run_cmd(1'b1, 1, 1'b0, -1);     // up one detent
        run_cmd(1'b0, 2, 1'b1, -1);     // down two detents with noise
        run_cmd(1'b0, 0, 1'b0, -1);     // empty command
        run_cmd(1'b1, 3, 1'b1, 21);     // reset mid-run
        run_cmd(1'b1, 255, 1'b0, -1);   // largest count, saturates position
        run_cmd(1'b1, 101, 1'b0, -1);   // stays at 100
        run_cmd(1'b0, 1, 1'b0, -1);     // back to 99

        for (int i = 0; i < 20; i++) begin
            run_cmd(1'($urandom), int'($urandom_range(0, 5)), 1'b1, -1);
        end

        @(negedge clk);
        chk_idle("final");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
